// File: rtl/samp_fifo_param_if.sv
// samp_fifo_param_if: producer/consumer bundle for the I/Q sample FIFO.
// master drives requests and write data; slave (the FIFO) returns status.
interface samp_fifo_param_if #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             PushIn;
  logic [WIDTH-1:0] SampI;
  logic [WIDTH-1:0] SampQ;
  logic             PullOut;
  logic             ClearErr;
  logic [WIDTH-1:0] OutI;
  logic [WIDTH-1:0] OutQ;
  logic             OutValid;
  logic             Full;
  logic             Empty;
  logic             AlmostFull;
  logic             AlmostEmpty;
  logic [CW-1:0]    Count;
  logic             Overflow;
  logic             Underflow;

  modport master (
    output PushIn, SampI, SampQ,
    output PullOut, ClearErr,
    input  OutI, OutQ, OutValid,
    input  Full, Empty,
    input  AlmostFull, AlmostEmpty,
    input  Count, Overflow, Underflow
  );

  modport slave (
    input  PushIn, SampI, SampQ,
    input  PullOut, ClearErr,
    output OutI, OutQ, OutValid,
    output Full, Empty,
    output AlmostFull, AlmostEmpty,
    output Count, Overflow, Underflow
  );
endinterface

// File: rtl/samp_fifo_param.sv
// samp_fifo_param: parametrised first-word-fall-through I/Q sample FIFO
// with occupancy count, almost flags and sticky overflow/underflow.
module samp_fifo_param #(
  parameter int WIDTH      = 24,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = 6,
  parameter int AEMPTY_LVL = 1
) (
  input logic             Clk,
  input logic             Reset,
  samp_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pull_ok;
  logic          ovf_evt;
  logic          udf_evt;
  logic [2*WIDTH-1:0] head;

  // Pointer-based full/empty; the extra MSB tells a wrap apart.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
            (wptr_q[AW] != rptr_q[AW]);
  end

  // A pull frees a slot in the same cycle, so a full FIFO still
  // accepts a push when it is also being pulled.
  always_comb begin
    push_ok = bus.PushIn && (!full || bus.PullOut);
    pull_ok = bus.PullOut && !empty;
    ovf_evt = bus.PushIn && full && !bus.PullOut;
    udf_evt = bus.PullOut && empty;
  end

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (push_ok) wptr_d = wptr_q + CW'(1);
    if (pull_ok) rptr_d = rptr_q + CW'(1);
    unique case ({push_ok, pull_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (bus.ClearErr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (ovf_evt) ovf_d = 1'b1;
    if (udf_evt) udf_d = 1'b1;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Sample storage; contents are left as-is on reset.
  always_ff @(posedge Clk) begin
    if (!Reset && push_ok)
      mem_q[wptr_q[AW-1:0]] <= {bus.SampI, bus.SampQ};
  end

  // Head entry falls through; outputs forced to zero when empty.
  always_comb begin
    head            = mem_q[rptr_q[AW-1:0]];
    bus.OutI        = empty ? '0 : head[2*WIDTH-1:WIDTH];
    bus.OutQ        = empty ? '0 : head[WIDTH-1:0];
    bus.OutValid    = !empty;
    bus.Full        = full;
    bus.Empty       = empty;
    bus.AlmostFull  = (cnt_q >= CW'(AFULL_LVL));
    bus.AlmostEmpty = (cnt_q <= CW'(AEMPTY_LVL));
    bus.Count       = cnt_q;
    bus.Overflow    = ovf_q;
    bus.Underflow   = udf_q;
  end
endmodule

// File: tb/tb_samp_fifo_param.sv
// tb_samp_fifo_param: directed self-checking bench for samp_fifo_param
// (WIDTH=24, DEPTH=8, AFULL_LVL=6, AEMPTY_LVL=1).
module tb_samp_fifo_param;
  localparam int W = 24;
  localparam int D = 8;

  logic Clk;
  logic Reset;
  int   tests;
  int   fails;

  samp_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  samp_fifo_param #(
    .WIDTH(W), .DEPTH(D),
    .AFULL_LVL(6), .AEMPTY_LVL(1)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.PushIn   = 1'b0;
    bus.PullOut  = 1'b0;
    bus.ClearErr = 1'b0;
    bus.SampI    = '0;
    bus.SampQ    = '0;
  endtask

  task automatic test_reset();
    idle();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tests++;
    if (bus.Count !== 4'd0) begin
      fails++;
      $display("FAIL rst_count got %0d exp 0", bus.Count);
    end
    tests++;
    if ({bus.Empty, bus.OutValid, bus.Full} !== 3'b100) begin
      fails++;
      $display("FAIL rst_flags E/V/F got %b exp 100",
               {bus.Empty, bus.OutValid, bus.Full});
    end
    tests++;
    if ({bus.AlmostEmpty, bus.AlmostFull} !== 2'b10) begin
      fails++;
      $display("FAIL rst_almost AE/AF got %b exp 10",
               {bus.AlmostEmpty, bus.AlmostFull});
    end
    tests++;
    if ({bus.OutI, bus.OutQ} !== 48'h0) begin
      fails++;
      $display("FAIL rst_out got %h exp 0", {bus.OutI, bus.OutQ});
    end
    tests++;
    if ({bus.Overflow, bus.Underflow} !== 2'b00) begin
      fails++;
      $display("FAIL rst_err got %b exp 00",
               {bus.Overflow, bus.Underflow});
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 8; k++) begin
      bus.PushIn = 1'b1;
      bus.SampI  = 24'(k);
      bus.SampQ  = 24'h800000 + 24'(k);
      tick();
      tests++;
      if (bus.Count !== 4'(k + 1)) begin
        fails++;
        $display("FAIL fill_count k=%0d got %0d exp %0d",
                 k, bus.Count, k + 1);
      end
      tests++;
      if (bus.AlmostFull !== (k + 1 >= 6)) begin
        fails++;
        $display("FAIL fill_afull k=%0d got %b", k, bus.AlmostFull);
      end
      tests++;
      if (bus.Full !== (k == 7)) begin
        fails++;
        $display("FAIL fill_full k=%0d got %b", k, bus.Full);
      end
      tests++;
      if (bus.AlmostEmpty !== (k == 0)) begin
        fails++;
        $display("FAIL fill_aempty k=%0d got %b",
                 k, bus.AlmostEmpty);
      end
      tests++;
      if ({bus.OutValid, bus.OutI, bus.OutQ} !==
          {1'b1, 24'h0, 24'h800000}) begin
        fails++;
        $display("FAIL fill_head k=%0d got %b %h %h exp 1 0 800000",
                 k, bus.OutValid, bus.OutI, bus.OutQ);
      end
    end
    idle();
  endtask

  task automatic test_overflow();
    bus.PushIn = 1'b1;
    bus.SampI  = 24'hAAAAAA;
    bus.SampQ  = 24'hAAAAAA;
    tick();
    idle();
    tests++;
    if ({bus.Overflow, bus.Full, bus.Count} !== {2'b11, 4'd8}) begin
      fails++;
      $display("FAIL ovf_set O/F/C got %b %b %0d exp 1 1 8",
               bus.Overflow, bus.Full, bus.Count);
    end
    for (int k = 0; k < 8; k++) begin
      bus.PullOut = 1'b1;
      tests++;
      if ({bus.OutI, bus.OutQ} !==
          {24'(k), 24'h800000 + 24'(k)}) begin
        fails++;
        $display("FAIL drain k=%0d got %h %h exp %h %h", k,
                 bus.OutI, bus.OutQ, k, 24'h800000 + 24'(k));
      end
      tick();
    end
    idle();
    tests++;
    if ({bus.Empty, bus.Count, bus.OutI} !== {1'b1, 4'd0, 24'h0}) begin
      fails++;
      $display("FAIL drain_end E/C/I got %b %0d %h exp 1 0 0",
               bus.Empty, bus.Count, bus.OutI);
    end
    bus.ClearErr = 1'b1;
    tick();
    idle();
    tests++;
    if (bus.Overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear got %b exp 0", bus.Overflow);
    end
  endtask

  task automatic test_underflow();
    bus.PullOut = 1'b1;
    tick();
    idle();
    tests++;
    if ({bus.Underflow, bus.Count} !== {1'b1, 4'd0}) begin
      fails++;
      $display("FAIL udf_set U/C got %b %0d exp 1 0",
               bus.Underflow, bus.Count);
    end
    bus.ClearErr = 1'b1;
    tick();
    tests++;
    if (bus.Underflow !== 1'b0) begin
      fails++;
      $display("FAIL udf_clear got %b exp 0", bus.Underflow);
    end
    bus.PullOut = 1'b1;
    tick();
    idle();
    tests++;
    if (bus.Underflow !== 1'b1) begin
      fails++;
      $display("FAIL udf_clr_vs_evt got %b exp 1", bus.Underflow);
    end
    bus.ClearErr = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_i;
    for (int k = 0; k < 8; k++) begin
      bus.PushIn = 1'b1;
      bus.SampI  = 24'h100 + 24'(k);
      bus.SampQ  = 24'h500 + 24'(k);
      tick();
    end
    for (int j = 0; j < 20; j++) begin
      bus.PushIn  = 1'b1;
      bus.PullOut = 1'b1;
      bus.SampI   = 24'h200 + 24'(j);
      bus.SampQ   = 24'h600 + 24'(j);
      exp_i = (j < 8) ? 24'h100 + 24'(j) : 24'h200 + 24'(j - 8);
      tests++;
      if (bus.OutI !== exp_i) begin
        fails++;
        $display("FAIL b2b_data j=%0d got %h exp %h",
                 j, bus.OutI, exp_i);
      end
      tick();
      tests++;
      if ({bus.Count, bus.Full, bus.Overflow} !==
          {4'd8, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL b2b_state j=%0d C/F/O got %0d %b %b exp 8 1 0",
                 j, bus.Count, bus.Full, bus.Overflow);
      end
    end
    idle();
    for (int k = 0; k < 8; k++) begin
      bus.PullOut = 1'b1;
      tests++;
      if ({bus.OutI, bus.OutQ} !==
          {24'h20C + 24'(k), 24'h60C + 24'(k)}) begin
        fails++;
        $display("FAIL b2b_drain k=%0d got %h %h exp %h %h", k,
                 bus.OutI, bus.OutQ, 24'h20C + 24'(k),
                 24'h60C + 24'(k));
      end
      tick();
    end
    idle();
    tests++;
    if ({bus.Empty, bus.Underflow} !== 2'b10) begin
      fails++;
      $display("FAIL b2b_end E/U got %b exp 10",
               {bus.Empty, bus.Underflow});
    end
  endtask

  task automatic test_empty_push_pull();
    bus.PushIn  = 1'b1;
    bus.PullOut = 1'b1;
    bus.SampI   = 24'h123456;
    bus.SampQ   = 24'h654321;
    tick();
    idle();
    tests++;
    if ({bus.Count, bus.Underflow, bus.OutValid} !==
        {4'd1, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL epp_state C/U/V got %0d %b %b exp 1 1 1",
               bus.Count, bus.Underflow, bus.OutValid);
    end
    tests++;
    if ({bus.OutI, bus.OutQ} !== {24'h123456, 24'h654321}) begin
      fails++;
      $display("FAIL epp_data got %h %h exp 123456 654321",
               bus.OutI, bus.OutQ);
    end
    bus.PullOut = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin
      bus.PushIn = 1'b1;
      bus.SampI  = 24'h300 + 24'(k);
      bus.SampQ  = 24'h700 + 24'(k);
      tick();
    end
    idle();
    tests++;
    if ({bus.Count, bus.Underflow} !== {4'd5, 1'b1}) begin
      fails++;
      $display("FAIL rmid_pre C/U got %0d %b exp 5 1",
               bus.Count, bus.Underflow);
    end
    Reset       = 1'b1;
    bus.PushIn  = 1'b1;
    bus.SampI   = 24'h999999;
    bus.SampQ   = 24'h999999;
    tick();
    Reset = 1'b0;
    idle();
    tests++;
    if ({bus.Count, bus.Empty, bus.OutI} !== {4'd0, 1'b1, 24'h0}) begin
      fails++;
      $display("FAIL rmid_state C/E/I got %0d %b %h exp 0 1 0",
               bus.Count, bus.Empty, bus.OutI);
    end
    tests++;
    if ({bus.Overflow, bus.Underflow} !== 2'b00) begin
      fails++;
      $display("FAIL rmid_err got %b exp 00",
               {bus.Overflow, bus.Underflow});
    end
    bus.PushIn = 1'b1;
    bus.SampI  = 24'h777777;
    bus.SampQ  = 24'h0000AB;
    tick();
    idle();
    tests++;
    if ({bus.Count, bus.OutI, bus.OutQ} !==
        {4'd1, 24'h777777, 24'h0000AB}) begin
      fails++;
      $display("FAIL rmid_after C/I/Q got %0d %h %h exp 1 777777 ab",
               bus.Count, bus.OutI, bus.OutQ);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Reset = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_empty_push_pull();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/samp_fifo_param.md
# samp_fifo_param

Parametrised I/Q sample FIFO, successor to the fixed 4-entry, 24-bit sample buffer. It sits between the sample producer (PushIn/SampI/SampQ) and the downstream consumer (PullOut). It adds configurable width and depth, an occupancy count, almost-full and almost-empty thresholds, and sticky overflow and underflow error flags. Reads are first-word-fall-through: the head sample is always presented on the outputs while the FIFO is non-empty.

## Interface
Parameters:
- WIDTH, 24, bits per I and per Q component
- DEPTH, 8, number of entries; power of 2, ≥ 2
- AFULL_LVL, 6, AlmostFull asserted when Count ≥ AFULL_LVL; range 1..DEPTH
- AEMPTY_LVL, 1, AlmostEmpty asserted when Count ≤ AEMPTY_LVL; range 0..DEPTH-1

Ports (CW = $clog2(DEPTH)+1):
- Clk  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high reset
- PushIn  in  1  write request
- SampI  in  WIDTH  I component to write
- SampQ  in  WIDTH  Q component to write
- PullOut  in  1  read request; pops the head entry
- ClearErr  in  1  clears Overflow and Underflow
- OutI  out  WIDTH  head I component; 0 when Empty
- OutQ  out  WIDTH  head Q component; 0 when Empty
- OutValid  out  1  equals !Empty
- Full  out  1  Count == DEPTH
- Empty  out  1  Count == 0
- AlmostFull  out  1  Count ≥ AFULL_LVL
- AlmostEmpty  out  1  Count ≤ AEMPTY_LVL
- Count  out  CW  current occupancy, 0..DEPTH
- Overflow  out  1  sticky: a push was dropped
- Underflow  out  1  sticky: a pull hit an empty FIFO

## Operation
- Storage: DEPTH×(2·WIDTH) array, not reset.
- Read and write pointers are CW bits wide (extra wrap bit).
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - Pointers wrap modulo 2·DEPTH.
- Count is a register, updated each cycle by +1 (push only), -1 (pull only) or 0.
- Push accepted when PushIn && (!Full || PullOut) → write at wptr, wptr+1.
- Pull accepted when PullOut && !Empty → rptr+1.
- Full and PullOut in the same cycle: both are accepted; Count is unchanged and Full stays 1.
- Empty and PushIn && PullOut in the same cycle: the push is accepted and the pull is rejected.
  - Underflow is set.
  - Count becomes 1.
- Rejected push (PushIn && Full && !PullOut): data is discarded, Overflow ← 1, pointers and memory are unchanged.
- Rejected pull (PullOut && Empty): Underflow ← 1, no state change.
- ClearErr clears both flags. If ClearErr coincides with a new error event, the new event wins (flag = 1).
- All status outputs are combinational functions of registered state (pointers and Count). No extra register stage.

## Timing
- Reset (synchronous; sampled on the Clk edge) resets the following state:
  - rptr, wptr ← 0
  - Count ← 0
  - Overflow, Underflow ← 0
- Outputs after reset: Empty=1, OutValid=0, Full=0, AlmostEmpty=1, AlmostFull=0 (for AFULL_LVL ≥ 1), OutI=OutQ=0.
- Reset in mid-operation discards all contents at that edge. Any PushIn or PullOut in the same cycle is ignored.
- Write latency: a push at edge k is visible on OutI/OutQ with OutValid=1 after edge k if the FIFO was empty (1-cycle fall-through).
- Pull: the consumer samples OutI/OutQ in the cycle it asserts PullOut. The next entry appears after that edge.
- Count, Full, Empty and the Almost flags reflect accepted operations one edge after they occur.
- Overflow and Underflow assert at the edge following the offending request.
- Sustained throughput: one push and one pull per cycle, indefinitely, with no bubbles.

## Test plan
- Reset, then 8 pushes of I=k, Q=0x800000+k (k=0..7) with DEPTH=8 → Count steps 1..8, AlmostFull from Count=6, Full=1 after the 8th push; OutI=0 throughout, then 0 on the first push edge onward (head stays k=0).
- From full, push I=0xAAAAAA without pull → Overflow=1, Count=8. Drain 8 → outputs 0..7 in order, 0xAAAAAA absent, Empty=1, OutI=0.
- From empty, PullOut=1 for one cycle → Underflow=1, Count=0. Next cycle ClearErr=1 → Underflow=0. Then ClearErr=1 together with PullOut on empty → Underflow remains 1.
- From full, PushIn=PullOut=1 for 20 cycles with incrementing data → Count=8 constant, Full=1, Overflow=0, outputs in order; pointers wrap at least twice.
- From empty, PushIn=PullOut=1 with I=0x123456 → Count=1, Underflow=1, OutI=0x123456 next cycle.
- Reset asserted with Count=5 while PushIn=1 → next cycle Count=0, Empty=1, Overflow=Underflow=0; the previously stored data is never output.
